// File: rtl/miner_nonce_scheduler.sv
// -----------------------------------------------------------------------------
// miner_nonce_scheduler
//
// Feeds NUM_CORES double-SHA256 hasher pairs with interleaved nonces (core k
// gets base+k), sequences the rolled-loop cnt/feedback controls, scans a
// bounded nonce range taken from a work handshake, checks each core's final
// hash word against the difficulty and queues golden nonces in a
// first-word-fall-through FIFO.
//
// Ports
//   hash_clk, reset        sole clock; synchronous active-high reset
//   work_valid/work_ready  work handshake (work_ready = !reset)
//   work_midstate/data     midstate and 96-bit data tail for the new range
//   work_nonce_start/end   inclusive nonce range, end >= start
//   core_state/core_data   registered hasher inputs (core_data: 512 b per core)
//   core_cnt/core_feedback rolled-loop round counter and feedback select
//   core_hash2_hi          hash2[255:224] from each core
//   gn_valid/ready/nonce   golden nonce FIFO output
//   gn_overflow            sticky: a hit was dropped
//   range_done             one-cycle pulse when the range is fully checked
//   busy                   scanning or draining
// -----------------------------------------------------------------------------
module miner_nonce_scheduler #(
   parameter int NUM_CORES       = 2,
   parameter int LOOP_LOG2       = 0,
   parameter int RESULT_LAT      = 131,
   parameter int DIFF_BITS       = 32,
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic                   hash_clk,
   input  logic                   reset,
   input  logic                   work_valid,
   output logic                   work_ready,
   input  logic [255:0]           work_midstate,
   input  logic [95:0]            work_data,
   input  logic [31:0]            work_nonce_start,
   input  logic [31:0]            work_nonce_end,
   output logic [255:0]           core_state,
   output logic [NUM_CORES*512-1:0] core_data,
   output logic [5:0]             core_cnt,
   output logic                   core_feedback,
   input  logic [NUM_CORES*32-1:0] core_hash2_hi,
   output logic                   gn_valid,
   input  logic                   gn_ready,
   output logic [31:0]            gn_nonce,
   output logic                   gn_overflow,
   output logic                   range_done,
   output logic                   busy
);

   localparam logic [5:0]   LOOP_MASK  = 6'((1 << LOOP_LOG2) - 1);
   localparam int           FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int           PW         = FIFO_DEPTH_LOG2 + 1;
   localparam logic [PW-1:0] FIFO_FULL = PW'(FIFO_DEPTH);
   localparam int           DW         = $clog2(RESULT_LAT);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(RESULT_LAT - 1);
   localparam logic [32:0]  NC33       = 33'(NUM_CORES);
   localparam logic [32:0]  NC33_M1    = 33'(NUM_CORES - 1);
   // SHA-256 padding for an 80-byte block header tail.
   localparam logic [383:0] PAD = 384'h00000280_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_80000000;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                 state;
   logic [95:0]            data_buf;
   logic [32:0]            nonce_cur;    // 33 bits so the scan never wraps to 0
   logic [32:0]            nonce_end;
   logic [5:0]             cnt;
   logic [DW-1:0]          drain_cnt;
   logic [NUM_CORES-1:0]   tag_line   [RESULT_LAT];
   logic [31:0]            nonce_line [RESULT_LAT];
   logic [31:0]            fifo_mem   [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr, rd_ptr;

   logic                   accept, issue, last_issue;
   logic [5:0]             cnt_next;
   logic [NUM_CORES-1:0]   tag_in, hit;
   logic [NUM_CORES*512-1:0] core_data_next;
   logic                   push, extra_hit, pop, fifo_full, push_ok, drop;
   logic [31:0]            push_nonce;

   assign work_ready = !reset;
   assign accept     = work_valid && work_ready;
   assign busy       = (state != IDLE);
   assign core_cnt   = cnt;

   assign cnt_next   = (state == IDLE) ? 6'd0 : ((cnt + 6'd1) & LOOP_MASK);
   assign issue      = (state == RUN) && (cnt_next == 6'd0);
   assign last_issue = issue && ((nonce_cur + NC33_M1) >= nonce_end);

   // NOTE: every always_comb output gets a default before any conditional
   // assignment, so no path leaves a value held and no latch is inferred.
   always_comb begin
      tag_in         = '0;
      core_data_next = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         tag_in[k] = (nonce_cur + 33'(k)) <= nonce_end;
         core_data_next[k*512 +: 512] = {PAD, nonce_cur[31:0] + 32'(k), data_buf};
      end
   end

   // Results of the previous range are ignored in the acceptance cycle too.
   always_comb begin
      hit = '0;
      for (int k = 0; k < NUM_CORES; k++)
         hit[k] = tag_line[RESULT_LAT-1][k] && !accept &&
                  (core_hash2_hi[k*32 + 31 -: DIFF_BITS] == '0);
   end

   // Lowest-index hit wins the single push slot; further hits are dropped.
   always_comb begin
      push       = 1'b0;
      extra_hit  = 1'b0;
      push_nonce = nonce_line[RESULT_LAT-1];
      for (int k = 0; k < NUM_CORES; k++) begin
         if (hit[k]) begin
            if (push) begin
               extra_hit = 1'b1;
            end else begin
               push       = 1'b1;
               push_nonce = nonce_line[RESULT_LAT-1] + 32'(k);
            end
         end
      end
   end

   assign gn_valid  = (wr_ptr != rd_ptr);
   assign gn_nonce  = fifo_mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
   assign pop       = gn_valid && gn_ready;
   assign fifo_full = ((wr_ptr - rd_ptr) == FIFO_FULL);
   assign push_ok   = push && (!fifo_full || pop);
   assign drop      = push && fifo_full && !pop;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge hash_clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         core_feedback <= 1'b0;
         nonce_cur     <= '0;
         nonce_end     <= '0;
         data_buf      <= '0;
         drain_cnt     <= '0;
         core_state    <= '0;
         core_data     <= '0;
         range_done    <= 1'b0;
         gn_overflow   <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         for (int i = 0; i < RESULT_LAT; i++) tag_line[i] <= '0;
      end else begin
         cnt           <= cnt_next;
         core_feedback <= (cnt_next != 6'd0);
         range_done    <= 1'b0;

         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (drop || extra_hit) gn_overflow <= 1'b1;

         tag_line[0] <= issue ? tag_in : '0;
         for (int i = 1; i < RESULT_LAT; i++) tag_line[i] <= tag_line[i-1];

         if (issue) begin
            nonce_cur <= nonce_cur + NC33;
            core_data <= core_data_next;
         end

         case (state)
            RUN: begin
               if (last_issue) begin
                  state     <= DRAIN;
                  drain_cnt <= DRAIN_LOAD;
               end
            end
            DRAIN: begin
               // The final issue's entry is at the line output when the
               // counter reaches zero.
               if (drain_cnt == '0) begin
                  state         <= IDLE;
                  range_done    <= 1'b1;
                  cnt           <= '0;
                  core_feedback <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            default: ;
         endcase

         // New work preempts whatever is in flight.
         if (accept) begin
            state         <= RUN;
            cnt           <= '0;
            core_feedback <= 1'b0;
            nonce_cur     <= {1'b0, work_nonce_start};
            nonce_end     <= {1'b0, work_nonce_end};
            data_buf      <= work_data;
            core_state    <= work_midstate;
            range_done    <= 1'b0;
            for (int i = 0; i < RESULT_LAT; i++) tag_line[i] <= '0;
         end
      end
   end

   // NOTE: storage-only arrays carry no reset; validity lives in the tag bits
   // and FIFO pointers, which lets these map onto shift-register/RAM cells.
   always_ff @(posedge hash_clk) begin
      nonce_line[0] <= nonce_cur[31:0];
      for (int i = 1; i < RESULT_LAT; i++) nonce_line[i] <= nonce_line[i-1];
      if (push_ok) fifo_mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= push_nonce;
   end

endmodule
